clk_div_ctrl: RTL

//  Run-time programmable integer clock divider with glitch-free ratio changes and graceful start/stop.

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_cfg_slot.sv | 52 +++++
 rtl/clk_div_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and limits for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_cfg_slot.sv
// One-entry pending-ratio slot: valid/ready intake, illegal-ratio rejection with cfg_err pulse.
// Holds the accepted ratio until the divider FSM strobes apply at a period boundary.
module clk_div_cfg_slot
   import clk_div_pkg::*;
#(
   parameter int DIV_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             apply,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             pend_vld,
   output logic [DIV_W-1:0] pend_div
);

   logic             r_pend_vld;
   logic [DIV_W-1:0] r_pend_div;
   logic             r_cfg_err;
   logic             w_xfer;
   logic             w_illegal;

   assign w_xfer    = cfg_valid & ~r_pend_vld;
   assign w_illegal = (cfg_div < DIV_W'(DIV_MIN));

   // apply is only raised while the slot is full, and a transfer only happens while it is empty,
   // so the two never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_div <= '0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_err <= w_xfer & w_illegal;
         if (w_xfer && !w_illegal) begin
            r_pend_vld <= 1'b1;
            r_pend_div <= cfg_div;
         end else if (apply) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   assign cfg_ready = ~r_pend_vld;
   assign cfg_err   = r_cfg_err;
   assign pend_vld  = r_pend_vld;
   assign pend_div  = r_pend_div;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable integer clock divider with glitch-free ratio changes and graceful stop.
// Outputs are registered; ratio changes and stops only ever land on a period boundary.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             div_out,
   output logic             div_tick,
   output logic [DIV_W-1:0] cur_div,
   output logic             busy
);

   generate
      if (DEFAULT_DIV < DIV_MIN || DEFAULT_DIV > (2**DIV_W) - 1) begin : g_bad_default
         $error("clk_div_ctrl: DEFAULT_DIV outside legal ratio range");
      end
   endgenerate

   state_t           r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_cur_div;
   logic             r_div_out;
   logic             r_div_tick;

   logic             w_pend_vld;
   logic [DIV_W-1:0] w_pend_div;
   logic             w_wrap;
   logic             w_apply;
   logic [DIV_W-1:0] w_cnt_inc;
   logic [DIV_W-1:0] w_half;

   clk_div_cfg_slot #(.DIV_W(DIV_W)) u_cfg_slot (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .apply     (w_apply),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .pend_vld  (w_pend_vld),
      .pend_div  (w_pend_div)
   );

   assign w_wrap    = (r_state != STOP) && (r_cnt == r_cur_div - DIV_W'(1));
   assign w_apply   = w_pend_vld && ((r_state == STOP) || w_wrap);
   assign w_cnt_inc = r_cnt + DIV_W'(1);
   assign w_half    = r_cur_div >> 1;

   // Increment happens only below N-1, so cnt never exceeds 2**DIV_W-2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= STOP;
         r_cnt      <= '0;
         r_cur_div  <= DIV_W'(DEFAULT_DIV);
         r_div_out  <= 1'b0;
         r_div_tick <= 1'b0;
      end else begin
         if (w_apply) begin
            r_cur_div <= w_pend_div;
         end
         case (r_state)
            STOP: begin
               r_cnt      <= '0;
               r_div_out  <= en;
               r_div_tick <= en;
               if (en) begin
                  r_state <= RUN;
               end
            end
            RUN, DRAIN: begin
               if (w_wrap && (r_state == DRAIN) && !en) begin
                  r_state    <= STOP;
                  r_cnt      <= '0;
                  r_div_out  <= 1'b0;
                  r_div_tick <= 1'b0;
               end else begin
                  r_state    <= en ? RUN : DRAIN;
                  r_div_tick <= w_wrap;
                  if (w_wrap) begin
                     r_cnt     <= '0;
                     r_div_out <= 1'b1;
                  end else begin
                     r_cnt     <= w_cnt_inc;
                     r_div_out <= (w_cnt_inc < w_half);
                  end
               end
            end
            default: begin
               r_state    <= STOP;
               r_cnt      <= '0;
               r_div_out  <= 1'b0;
               r_div_tick <= 1'b0;
            end
         endcase
      end
   end

   assign div_out  = r_div_out;
   assign div_tick = r_div_tick;
   assign cur_div  = r_cur_div;
   assign busy     = (r_state != STOP);

endmodule
